fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the MIPS R2000 pipeline; successor to the single-PC IF stage.
- Holds the fetch PC and issues requests on a ready/valid instruction-memory port, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions, each with its PC, in a FIFO_DEPTH prefetch queue that feeds decode via a ready/valid handshake.
- Supports branch, jump and exception redirects with precise flushing of queued and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode-side queue head.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc4_out;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_out, pc_out, pc4_out,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_out, pc_out, pc4_out,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: multi-outstanding imem requests, prefetch queue, and
// redirect handling that squashes queued and in-flight fetches.
module fetch_unit #(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = 'h0040_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR      = 'h8000_0180,
  parameter int                FIFO_DEPTH      = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_pc4,
  input  logic [ADDR_W-1:0] sign,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] fixed,
  input  logic              except,
  fetch_unit_if.master      bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]     outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];

  logic              redirect, req_valid, req_fire, drop, push, pop, head_valid;
  logic [ADDR_W-1:0] target;
  logic [SW-1:0]     occ;
  entry_t            head;

  always_comb begin
    redirect = except | br | jmp;
    if (except)  target = EXC_VECTOR;
    else if (br) target = br_pc4 + (sign << 2);
    else         target = fixed;
    target = target & ~ADDR_W'(3);

    // Queue slots are reserved for every in-flight fetch, so a response can always be pushed.
    occ        = SW'(cnt_q) + SW'(outst_q);
    req_valid  = rst_n && !redirect && (outst_q < OW'(MAX_OUTSTANDING)) && (occ < SW'(FIFO_DEPTH));
    req_fire   = req_valid && bus.imem_req_ready;
    drop       = bus.imem_rsp_valid && (drop_q != '0);
    push       = bus.imem_rsp_valid && !drop && !redirect;
    head_valid = (cnt_q != '0);
    pop        = head_valid && bus.inst_ready && !redirect;

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    mem_d      = mem_q;
    outst_d    = outst_q + OW'(req_fire) - OW'(bus.imem_rsp_valid);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (drop)     drop_d     = drop_q - OW'(1);
    if (push) begin
      mem_d[wr_q] = '{inst: bus.imem_rsp_data, pc: rsp_pc_q};
      wr_d        = wr_q + PW'(1);
      rsp_pc_d    = rsp_pc_q + ADDR_W'(4);
    end
    if (pop) rd_d = rd_q + PW'(1);

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      drop_d     = outst_d;
    end

    head               = mem_q[rd_q];
    bus.imem_req_valid = req_valid;
    bus.imem_addr      = fetch_pc_q;
    bus.inst_valid     = head_valid;
    bus.inst_out       = head_valid ? head.inst : '0;
    bus.pc_out         = head_valid ? head.pc : '0;
    bus.pc4_out        = head_valid ? head.pc + ADDR_W'(4) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for streaming, stall and
// reset, plus hand sequences for branch/exception/jump redirects.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br = 1'b0, jmp = 1'b0, except = 1'b0;
  logic [31:0] br_pc4 = '0, sign = '0, fixed = '0;
  bit          hold = 1'b0;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] mq[$];

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .br(br), .br_pc4(br_pc4), .sign(sign),
    .jmp(jmp), .fixed(fixed), .except(except), .bus(bus)
  );

  always #5 clk = ~clk;

  // In-order memory: one-cycle response latency, responses can be held back.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) mq.push_back(bus.imem_addr);
      #1;
      if (!hold && mq.size() > 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ~mq.pop_front();
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  typedef struct {
    logic        rst_n;
    logic        irdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(logic r, logic i, logic rv, logic [31:0] a, logic iv, logic [31:0] pc);
    vec_t v;
    v.rst_n = r; v.irdy = i; v.exp_rv = rv; v.exp_addr = a; v.exp_iv = iv; v.exp_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; br = 0; jmp = 0; except = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_inst(input int max, input string name);
    int k = 0;
    @(negedge clk);
    while (!bus.inst_valid && k < max) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, {31'b0, bus.inst_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[30];
    tbl[0]  = mk(1, 1, 1, 32'h0040_0000, 0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 32'h0040_0004, 0, 32'h0);
    tbl[2]  = mk(1, 1, 1, 32'h0040_0008, 1, 32'h0040_0000);
    tbl[3]  = mk(1, 1, 1, 32'h0040_000C, 1, 32'h0040_0004);
    tbl[4]  = mk(1, 1, 1, 32'h0040_0010, 1, 32'h0040_0008);
    tbl[5]  = mk(1, 1, 1, 32'h0040_0014, 1, 32'h0040_000C);
    tbl[6]  = mk(0, 1, 0, 32'h0,         0, 32'h0);
    tbl[7]  = mk(1, 0, 1, 32'h0040_0000, 0, 32'h0);
    tbl[8]  = mk(1, 0, 1, 32'h0040_0004, 0, 32'h0);
    tbl[9]  = mk(1, 0, 1, 32'h0040_0008, 1, 32'h0040_0000);
    tbl[10] = mk(1, 0, 1, 32'h0040_000C, 1, 32'h0040_0000);
    for (int i = 11; i <= 16; i++) tbl[i] = mk(1, 0, 0, 32'h0, 1, 32'h0040_0000);
    tbl[17] = mk(1, 1, 0, 32'h0,         1, 32'h0040_0000);
    tbl[18] = mk(1, 1, 1, 32'h0040_0010, 1, 32'h0040_0004);
    tbl[19] = mk(1, 1, 1, 32'h0040_0014, 1, 32'h0040_0008);
    tbl[20] = mk(1, 1, 1, 32'h0040_0018, 1, 32'h0040_000C);
    tbl[21] = mk(1, 1, 1, 32'h0040_001C, 1, 32'h0040_0010);
    tbl[22] = mk(1, 1, 1, 32'h0040_0020, 1, 32'h0040_0014);
    tbl[23] = mk(1, 0, 1, 32'h0040_0024, 1, 32'h0040_0018);
    tbl[24] = mk(1, 0, 0, 32'h0,         1, 32'h0040_0018);
    tbl[25] = mk(1, 0, 0, 32'h0,         1, 32'h0040_0018);
    tbl[26] = mk(0, 0, 0, 32'h0,         0, 32'h0);
    tbl[27] = mk(1, 1, 1, 32'h0040_0000, 0, 32'h0);
    tbl[28] = mk(1, 1, 1, 32'h0040_0004, 0, 32'h0);
    tbl[29] = mk(1, 1, 1, 32'h0040_0008, 1, 32'h0040_0000);

    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;

    @(negedge clk);
    chk("rst_req_valid",  {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst_out",   bus.inst_out, 32'd0);
    chk("rst_pc_out",     bus.pc_out, 32'd0);
    chk("rst_pc4_out",    bus.pc4_out, 32'd0);
    tick();

    foreach (tbl[i]) begin
      rst_n          = tbl[i].rst_n;
      bus.inst_ready = tbl[i].irdy;
      @(negedge clk);
      chk($sformatf("row%0d_req_valid", i), {31'b0, bus.imem_req_valid}, {31'b0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) chk($sformatf("row%0d_addr", i), bus.imem_addr, tbl[i].exp_addr);
      chk($sformatf("row%0d_inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, tbl[i].exp_iv});
      chk($sformatf("row%0d_pc_out", i), bus.pc_out, tbl[i].exp_pc);
      chk($sformatf("row%0d_inst_out", i), bus.inst_out, tbl[i].exp_iv ? ~tbl[i].exp_pc : 32'h0);
      chk($sformatf("row%0d_pc4_out", i), bus.pc4_out, tbl[i].exp_iv ? tbl[i].exp_pc + 32'd4 : 32'h0);
      tick();
    end

    // Branch with two fetches in flight: both stale responses must be dropped.
    bus.inst_ready = 1'b1;
    reset_dut();
    hold = 1'b1;
    tick();
    tick();
    br = 1'b1; br_pc4 = 32'h0040_0010; sign = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("br_cycle_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    tick();
    br = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("br_target_addr", bus.imem_addr, 32'h0040_0008);
    chk("br_full_outst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    tick();
    wait_inst(20, "br_first");
    chk("br_first_pc", bus.pc_out, 32'h0040_0008);
    chk("br_first_inst", bus.inst_out, ~32'h0040_0008);
    chk("br_first_pc4", bus.pc4_out, 32'h0040_000C);
    tick();
    @(negedge clk);
    chk("br_second_pc", bus.pc_out, 32'h0040_000C);

    // Exception and branch together: exception wins.
    reset_dut();
    repeat (4) tick();
    except = 1'b1; br = 1'b1; br_pc4 = 32'h0040_0010; sign = 32'h0000_0004;
    @(negedge clk);
    chk("exc_cycle_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    tick();
    except = 1'b0; br = 1'b0;
    @(negedge clk);
    chk("exc_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("exc_addr", bus.imem_addr, 32'h8000_0180);
    chk("exc_queue_flushed", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    wait_inst(20, "exc_first");
    chk("exc_first_pc", bus.pc_out, 32'h8000_0180);
    chk("exc_first_inst", bus.inst_out, ~32'h8000_0180);

    // Jump to an unaligned target: low bits forced to zero.
    tick();
    jmp = 1'b1; fixed = 32'h0040_0103;
    @(negedge clk);
    chk("jmp_cycle_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    tick();
    jmp = 1'b0;
    @(negedge clk);
    chk("jmp_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("jmp_addr", bus.imem_addr, 32'h0040_0100);
    chk("jmp_queue_flushed", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    wait_inst(20, "jmp_first");
    chk("jmp_first_pc", bus.pc_out, 32'h0040_0100);
    chk("jmp_first_pc4", bus.pc4_out, 32'h0040_0104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
